// File: rtl/lms_filter_seq.sv
// Time-multiplexed adaptive LMS FIR filter.
// One shared multiplier walks the taps to form y = sum w[i]*x[n-i], then forms err = d - y,
// then optionally walks the taps again applying w[i] += (err*x[n-i]) >>> (FRAC_BITS+mu).
// All datapath results saturate; any clip raises the sticky sat_flag.
module lms_filter_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int FRAC_BITS  = 14,
    parameter int ACC_WIDTH  = 40,
    parameter int TAPS       = 8,
    parameter int MU_W       = 5,
    localparam int AW        = $clog2(TAPS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] d_in,
    input  logic        [MU_W-1:0]       mu_shift,
    input  logic                         adapt_en,
    input  logic                         clear_w,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] y_out,
    output logic signed [DATA_WIDTH-1:0] err_out,
    output logic                         sat_flag,
    input  logic        [AW-1:0]         w_rd_addr,
    output logic signed [COEF_WIDTH-1:0] w_rd_data
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH;  // x*w product width
    localparam int EW = 2 * DATA_WIDTH;           // err*x product width
    localparam int UW = EW + 1;                   // weight update sum width

    typedef enum logic [1:0] {S_IDLE, S_FILTER, S_ERR, S_UPDATE} state_t;

    // True when an accumulator-width value is representable in DATA_WIDTH bits.
    function automatic logic fits_data(input logic signed [ACC_WIDTH-1:0] v);
        return (v[ACC_WIDTH-1:DATA_WIDTH-1] == {(ACC_WIDTH-DATA_WIDTH+1){v[DATA_WIDTH-1]}});
    endfunction

    // Clip an accumulator-width value to the DATA_WIDTH range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_data(input logic signed [ACC_WIDTH-1:0] v);
        if (fits_data(v)) begin
            return v[DATA_WIDTH-1:0];
        end else if (v[ACC_WIDTH-1]) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    endfunction

    // True when an update-sum value is representable in COEF_WIDTH bits.
    function automatic logic fits_coef(input logic signed [UW-1:0] v);
        return (v[UW-1:COEF_WIDTH-1] == {(UW-COEF_WIDTH+1){v[COEF_WIDTH-1]}});
    endfunction

    // Clip an update-sum value to the COEF_WIDTH range.
    function automatic logic signed [COEF_WIDTH-1:0] sat_coef(input logic signed [UW-1:0] v);
        if (fits_coef(v)) begin
            return v[COEF_WIDTH-1:0];
        end else if (v[UW-1]) begin
            return {1'b1, {(COEF_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(COEF_WIDTH-1){1'b1}}};
        end
    endfunction

    state_t                         state_q;
    logic        [AW-1:0]           idx_q;
    logic signed [DATA_WIDTH-1:0]   x_q [TAPS];
    logic signed [COEF_WIDTH-1:0]   w_q [TAPS];
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [DATA_WIDTH-1:0]   d_q;
    logic signed [DATA_WIDTH-1:0]   e_q;
    logic signed [DATA_WIDTH-1:0]   y_q;
    logic signed [DATA_WIDTH-1:0]   err_q;
    logic        [MU_W-1:0]         mu_q;
    logic                           adapt_q;
    logic                           out_valid_q;
    logic                           sat_q;

    logic signed [DATA_WIDTH-1:0]   x_cur_s;
    logic signed [COEF_WIDTH-1:0]   w_cur_s;
    logic signed [PW-1:0]           mac_prod_s;
    logic signed [ACC_WIDTH-1:0]    acc_d;
    logic signed [ACC_WIDTH-1:0]    y_wide_s;
    logic signed [DATA_WIDTH-1:0]   y_d;
    logic                           y_clip_s;
    logic signed [DATA_WIDTH:0]     diff_s;
    logic signed [ACC_WIDTH-1:0]    e_wide_s;
    logic signed [DATA_WIDTH-1:0]   e_d;
    logic                           e_clip_s;
    logic signed [EW-1:0]           upd_prod_s;
    logic signed [EW-1:0]           upd_delta_s;
    logic signed [UW-1:0]           w_sum_s;
    logic signed [COEF_WIDTH-1:0]   w_upd_d;
    logic                           w_clip_s;
    logic signed [COEF_WIDTH-1:0]   w_rd_s;

    // Shared datapath: MAC step, output/error formation and weight update for the current tap.
    always_comb begin
        x_cur_s     = x_q[idx_q];
        w_cur_s     = w_q[idx_q];
        mac_prod_s  = PW'(x_cur_s) * PW'(w_cur_s);
        acc_d       = acc_q + ACC_WIDTH'(mac_prod_s);
        y_wide_s    = acc_q >>> FRAC_BITS;
        y_clip_s    = !fits_data(y_wide_s);
        y_d         = sat_data(y_wide_s);
        diff_s      = (DATA_WIDTH+1)'(d_q) - (DATA_WIDTH+1)'(y_d);
        e_wide_s    = ACC_WIDTH'(diff_s);
        e_clip_s    = !fits_data(e_wide_s);
        e_d         = sat_data(e_wide_s);
        upd_prod_s  = EW'(e_q) * EW'(x_cur_s);
        upd_delta_s = upd_prod_s >>> (FRAC_BITS + int'(mu_q));
        w_sum_s     = UW'(w_cur_s) + UW'(upd_delta_s);
        w_clip_s    = !fits_coef(w_sum_s);
        w_upd_d     = sat_coef(w_sum_s);
    end

    // Weight readback mux; addresses with no tap behind them read as zero.
    always_comb begin
        w_rd_s = '0;
        for (int i = 0; i < TAPS; i++) begin
            w_rd_s = (w_rd_addr == AW'(i)) ? w_q[i] : w_rd_s;
        end
    end

    // Sequencer: accept, MAC over taps, form outputs, optional weight update, with clear/reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            d_q         <= '0;
            e_q         <= '0;
            y_q         <= '0;
            err_q       <= '0;
            mu_q        <= '0;
            adapt_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else if (clear_w) begin
            // Drop any in-flight sample; delay line and held outputs survive.
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q[0] <= x_in;
                        for (int i = 1; i < TAPS; i++) begin
                            x_q[i] <= x_q[i-1];
                        end
                        d_q     <= d_in;
                        mu_q    <= mu_shift;
                        adapt_q <= adapt_en;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_FILTER;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FILTER: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + AW'(1);
                    if (idx_q == AW'(TAPS-1)) begin
                        state_q <= S_ERR;
                    end else begin
                        state_q <= S_FILTER;
                    end
                end
                S_ERR: begin
                    y_q         <= y_d;
                    err_q       <= e_d;
                    e_q         <= e_d;
                    out_valid_q <= 1'b1;
                    sat_q       <= sat_q | y_clip_s | e_clip_s;
                    idx_q       <= '0;
                    state_q     <= adapt_q ? S_UPDATE : S_IDLE;
                end
                S_UPDATE: begin
                    w_q[idx_q] <= w_upd_d;
                    sat_q      <= sat_q | w_clip_s;
                    idx_q      <= idx_q + AW'(1);
                    if (idx_q == AW'(TAPS-1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_UPDATE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && reset;
    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign err_out   = err_q;
    assign sat_flag  = sat_q;
    assign w_rd_data = w_rd_s;

endmodule
